fp32_adder_arbiter: RTL and testbench
=====================================

Name: fp32_adder_arbiter

Overview:
Shares one fp32 adder (sequential, strobe/ack handshaked, one operation in flight) between N_REQ requesters. Each requester presents an operand pair on a valid/ready port. A round-robin arbiter picks one, the block sequences the adder's operand-A, operand-B and result handshakes, then returns the sum on a valid/ready response port tagged with the requester index. It sits between client datapaths and the adder instance at the top of the fp32 adder subsystem.

Parameters:
N_REQ, 4, number of requesters (1..16)
IDX_W, $clog2(N_REQ) min 1, width of requester index
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester request accept (one-hot or zero)
req_a  in  N_REQ*32  operand A per requester, slot i at [32*i+:32]
req_b  in  N_REQ*32  operand B per requester
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_z  out  32  fp32 sum
rsp_idx  out  IDX_W  requester index owning rsp_z
adder_a  out  32  to adder input_a
adder_a_stb  out  1  to adder input_a_stb
adder_a_ack  in  1  from adder input_a_ack
adder_b  out  32  to adder input_b
adder_b_stb  out  1  to adder input_b_stb
adder_b_ack  in  1  from adder input_b_ack
adder_z  in  32  from adder output_z
adder_z_stb  in  1  from adder output_z_stb
adder_z_ack  out  1  to adder output_z_ack
busy  out  1  high in any state other than IDLE
ops_done  out  CNT_W  completed responses, wraps at 2^CNT_W

Behaviour:
- Reset (async assert, sync release by integration): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_z=0, rsp_idx=0, adder_*_stb=0, adder_z_ack=0, ops_done=0, busy=0. The adder is reset from the same source (~rst_n); reset mid-operation abandons the op with no response.
- States: IDLE -> SEND_A -> SEND_B -> WAIT_Z -> RESP -> IDLE.
- IDLE: if any req_valid, grant g = first set bit searching from rr_ptr upward with wrap. req_ready[g]=1 combinationally this cycle only. On that edge, latch op_a/op_b/idx=g, set rr_ptr=(g+1) mod N_REQ, go to SEND_A. No request: stay; rr_ptr unchanged.
- SEND_A: adder_a=op_a, adder_a_stb=1. Transfer on the edge with adder_a_stb&&adder_a_ack, then go to SEND_B. Wait indefinitely otherwise.
- SEND_B: same with B. Transfer edge -> WAIT_Z.
- WAIT_Z: adder_z_ack=1. On the edge with adder_z_stb&&adder_z_ack, capture rsp_z=adder_z, rsp_idx=idx, then go to RESP.
- RESP: rsp_valid=1, rsp_z/rsp_idx stable. On rsp_valid&&rsp_ready: ops_done+=1 (wrap), go to IDLE. No arbitration in RESP; request backpressure holds.
- Strobes and acks are registered outputs decoded from state; no combinational input->output path except req_ready from req_valid.
- Minimum latency, request accept to rsp_valid: 3 + adder compute cycles. Minimum gap between grants: one IDLE cycle.
- Operand data is latched at grant; requester changes after accept have no effect.
- N_REQ=1: rr_ptr is a constant 0; grant whenever req_valid[0].
- req_valid deasserted before grant: no grant, no side effects.

Decomposition:
- Package fp32_adder_pkg: state enum (IDLE, SEND_A, SEND_B, WAIT_Z, RESP), FP32_W=32, constants FP32_POS_ZERO, FP32_QNAN=32'hFFC00000 for benches.
- Sub-module rr_arbiter (N, inputs req and ptr, outputs one-hot grant, index and any). Pure combinational, reusable.

Test Plan:
- Single op: req0 a=0x3F800000, b=0x40000000 -> rsp_valid with rsp_z=0x40400000, rsp_idx=0, ops_done=1.
- All four valid continuously with distinct operands -> grants in order 0,1,2,3,0; each rsp_idx matches; no starvation over 20 ops.
- rr_ptr=2, only req1 and req3 valid -> req3 granted first, then req1.
- rsp_ready low for 10 cycles in RESP -> rsp_valid and rsp_z held, req_ready all 0, adder strobes 0; accepted on the 11th cycle.
- Adder acks delayed by 5 cycles (stub) -> adder_a_stb held high with adder_a stable until the ack; exactly one transfer per operand.
- rst_n pulsed low during WAIT_Z -> all outputs reset immediately (async); after release a fresh op 0xBF800000+0x3F800000 -> 0x00000000.

Source files
------------

// File: rtl/fp32_adder_pkg.sv
// Shared types and constants for the fp32 adder subsystem.
package fp32_adder_pkg;

  localparam int unsigned FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_QNAN     = 32'hFFC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    RESP
  } state_e;

  typedef struct packed {
    logic [FP32_W-1:0] a;
    logic [FP32_W-1:0] b;
  } fp32_pair_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] req_rot;

  // Rotate so ptr_i lands at bit 0, then take the lowest set bit.
  always_comb begin
    req_rot = N'({req_i, req_i} >> ptr_i);
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_o && req_rot[k]) begin
        any_o = 1'b1;
        idx_o = IW'((32'(ptr_i) + k) % N);
      end
    end
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fp32_adder_arbiter.sv
// Shares one handshaked sequential fp32 adder among N_REQ requesters with
// round-robin arbitration; one operation in flight, response tagged with index.
module fp32_adder_arbiter
  import fp32_adder_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*FP32_W-1:0]   req_a,
  input  logic [N_REQ*FP32_W-1:0]   req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [FP32_W-1:0]         rsp_z,
  output logic [IDX_W-1:0]          rsp_idx,
  output logic [FP32_W-1:0]         adder_a,
  output logic                      adder_a_stb,
  input  logic                      adder_a_ack,
  output logic [FP32_W-1:0]         adder_b,
  output logic                      adder_b_stb,
  input  logic                      adder_b_ack,
  input  logic [FP32_W-1:0]         adder_z,
  input  logic                      adder_z_stb,
  output logic                      adder_z_ack,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_done
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  fp32_pair_t         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FP32_W-1:0]  rsp_z_q, rsp_z_d;
  logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               a_stb_q, a_stb_d;
  logic               b_stb_q, b_stb_d;
  logic               z_ack_q, z_ack_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic [N_REQ-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  fp32_pair_t         sel_op;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Only combinational output path: grant is visible in IDLE, never in reset.
  assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;

  always_comb begin
    sel_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op.a = req_a[FP32_W*i +: FP32_W];
        sel_op.b = req_b[FP32_W*i +: FP32_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    idx_d      = idx_q;
    rsp_z_d    = rsp_z_q;
    rsp_idx_d  = rsp_idx_q;
    ops_done_d = ops_done_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          op_d     = sel_op;
          idx_d    = grant_idx;
          rr_ptr_d = IDX_W'((32'(grant_idx) + 1) % N_REQ);
          state_d  = SEND_A;
        end
      end
      SEND_A: if (a_stb_q && adder_a_ack) state_d = SEND_B;
      SEND_B: if (b_stb_q && adder_b_ack) state_d = WAIT_Z;
      WAIT_Z: begin
        if (z_ack_q && adder_z_stb) begin
          rsp_z_d   = adder_z;
          rsp_idx_d = idx_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    a_stb_d     = (state_d == SEND_A);
    b_stb_d     = (state_d == SEND_B);
    z_ack_d     = (state_d == WAIT_Z);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      rsp_z_q     <= FP32_POS_ZERO;
      rsp_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      rsp_z_q     <= rsp_z_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_valid_q <= rsp_valid_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      z_ack_q     <= z_ack_d;
      busy_q      <= busy_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign adder_a     = op_q.a;
  assign adder_b     = op_q.b;
  assign adder_a_stb = a_stb_q;
  assign adder_b_stb = b_stb_q;
  assign adder_z_ack = z_ack_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_z       = rsp_z_q;
  assign rsp_idx     = rsp_idx_q;
  assign busy        = busy_q;
  assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_fp32_adder_arbiter.sv
// Directed bench for fp32_adder_arbiter with a handshaked adder stub whose
// sums come from a small table of hand-computed fp32 results.
module tb_fp32_adder_arbiter;
  import fp32_adder_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_z;
  logic [IW-1:0]   rsp_idx;
  logic [31:0]     adder_a;
  logic            adder_a_stb;
  logic            adder_a_ack;
  logic [31:0]     adder_b;
  logic            adder_b_stb;
  logic            adder_b_ack;
  logic [31:0]     adder_z;
  logic            adder_z_stb;
  logic            adder_z_ack;
  logic            busy;
  logic [CW-1:0]   ops_done;

  logic [31:0] op_a_tb [0:N-1];
  logic [31:0] op_b_tb [0:N-1];

  int checks = 0;
  int errors = 0;

  int ack_dly = 0;
  int z_dly   = 1;
  int phase;
  int cnt;
  logic [31:0] sa, sb;
  int a_xfers = 0, b_xfers = 0, z_xfers = 0;
  int a_stb_edges = 0, a_unstable = 0;
  logic        a_seen;
  logic [31:0] a_first;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[32*g +: 32] = op_a_tb[g];
    assign req_b[32*g +: 32] = op_b_tb[g];
  end

  fp32_adder_arbiter #(
    .N_REQ (N),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_z       (rsp_z),
    .rsp_idx     (rsp_idx),
    .adder_a     (adder_a),
    .adder_a_stb (adder_a_stb),
    .adder_a_ack (adder_a_ack),
    .adder_b     (adder_b),
    .adder_b_stb (adder_b_stb),
    .adder_b_ack (adder_b_ack),
    .adder_z     (adder_z),
    .adder_z_stb (adder_z_stb),
    .adder_z_ack (adder_z_ack),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;
      {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;
      {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;
      {32'h4080_0000, 32'h3F80_0000}: return 32'h40A0_0000;
      {32'hBF80_0000, 32'h3F80_0000}: return 32'h0000_0000;
      default:                        return FP32_QNAN;
    endcase
  endfunction

  // Adder stub: acks each operand ack_dly edges after its strobe, result z_dly later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= 0;
      cnt         <= 0;
      adder_a_ack <= 1'b0;
      adder_b_ack <= 1'b0;
      adder_z_stb <= 1'b0;
      adder_z     <= '0;
      a_seen      <= 1'b0;
    end else begin
      if (adder_a_stb) begin
        a_stb_edges <= a_stb_edges + 1;
        if (!a_seen) begin
          a_seen  <= 1'b1;
          a_first <= adder_a;
        end else if (adder_a !== a_first) begin
          a_unstable <= a_unstable + 1;
        end
      end
      case (phase)
        0: if (adder_a_stb) begin
          if (adder_a_ack) begin
            adder_a_ack <= 1'b0;
            sa          <= adder_a;
            a_xfers     <= a_xfers + 1;
            a_seen      <= 1'b0;
            cnt         <= 0;
            phase       <= 1;
          end else if (cnt >= ack_dly) adder_a_ack <= 1'b1;
          else cnt <= cnt + 1;
        end
        1: if (adder_b_stb) begin
          if (adder_b_ack) begin
            adder_b_ack <= 1'b0;
            sb          <= adder_b;
            b_xfers     <= b_xfers + 1;
            cnt         <= 0;
            phase       <= 2;
          end else if (cnt >= ack_dly) adder_b_ack <= 1'b1;
          else cnt <= cnt + 1;
        end
        2: if (adder_z_stb) begin
          if (adder_z_ack) begin
            adder_z_stb <= 1'b0;
            z_xfers     <= z_xfers + 1;
            cnt         <= 0;
            phase       <= 0;
          end
        end else if (cnt >= z_dly) begin
          adder_z_stb <= 1'b1;
          adder_z     <= fp_sum(sa, sb);
        end else cnt <= cnt + 1;
        default: phase <= 0;
      endcase
    end
  end

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    ack_dly   = 0;
    z_dly     = 1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Raise valid on one port and hold it until the grant edge; ok=0 on timeout.
  task automatic issue(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] b,
                       output bit ok);
    op_a_tb[idx]   = a;
    op_b_tb[idx]   = b;
    req_valid[idx] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_z !== 32'h0) begin errors++; $display("FAIL reset_rsp_z got %h want 0", rsp_z); end
    checks++; if (rsp_idx !== 2'd0) begin errors++; $display("FAIL reset_rsp_idx got %0d want 0", rsp_idx); end
    checks++; if ({adder_a_stb, adder_b_stb, adder_z_ack} !== 3'b000) begin errors++; $display("FAIL reset_handshake got %b want 000", {adder_a_stb, adder_b_stb, adder_z_ack}); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    bit ok;
    do_reset();
    issue(2'd0, 32'h3F80_0000, 32'h4000_0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_grant got timeout want grant"); end
    op_a_tb[0] = FP32_QNAN;
    op_b_tb[0] = FP32_QNAN;
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp got timeout want rsp_valid"); end
    checks++; if (rsp_z !== 32'h4040_0000) begin errors++; $display("FAIL single_z got %h want 40400000", rsp_z); end
    checks++; if (rsp_idx !== 2'd0) begin errors++; $display("FAIL single_idx got %0d want 0", rsp_idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_resp got %b want 1", busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
    checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_done got %0d want 1", ops_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_no_grant();
    bit ok;
    do_reset();
    #1 req_valid[2] = 1'b1;
    #2 req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nogrant_busy got %b want 0", busy); end
    checks++; if (adder_a_stb !== 1'b0) begin errors++; $display("FAIL nogrant_a_stb got %b want 0", adder_a_stb); end
    op_a_tb[0] = 32'h3F80_0000; op_b_tb[0] = 32'h3F80_0000;
    op_a_tb[2] = 32'h4000_0000; op_b_tb[2] = 32'h3F80_0000;
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL nogrant_ptr_kept got %b want 0001", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(ok);
    checks++; if (!ok || rsp_idx !== 2'd0 || rsp_z !== 32'h4000_0000) begin errors++; $display("FAIL nogrant_rsp got ok=%b idx=%0d z=%h want ok=1 idx=0 z=40000000", ok, rsp_idx, rsp_z); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] exp_z [0:3];
    exp_z[0] = 32'h4000_0000; exp_z[1] = 32'h4040_0000;
    exp_z[2] = 32'h4080_0000; exp_z[3] = 32'h40A0_0000;
    do_reset();
    op_a_tb[0] = 32'h3F80_0000; op_a_tb[1] = 32'h4000_0000;
    op_a_tb[2] = 32'h4040_0000; op_a_tb[3] = 32'h4080_0000;
    for (int i = 0; i < 4; i++) op_b_tb[i] = 32'h3F80_0000;
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      wait_rsp(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_rsp_%0d got timeout want rsp_valid", k); end
      checks++; if (rsp_idx !== 2'(k)) begin errors++; $display("FAIL rr_idx_%0d got %0d want %0d", k, rsp_idx, k % 4); end
      checks++; if (rsp_z !== exp_z[k % 4]) begin errors++; $display("FAIL rr_z_%0d got %h want %h", k, rsp_z, exp_z[k % 4]); end
      if (k == 19) req_valid = '0;
    end
    @(negedge clk);
    checks++; if (ops_done !== 16'd20) begin errors++; $display("FAIL rr_ops_done got %0d want 20", ops_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b want 0", busy); end
  endtask

  task automatic test_ptr_wrap();
    bit ok;
    do_reset();
    issue(2'd1, 32'h3F80_0000, 32'h3F80_0000, ok);
    wait_rsp(ok);
    checks++; if (!ok || rsp_idx !== 2'd1) begin errors++; $display("FAIL ptr_setup got ok=%b idx=%0d want ok=1 idx=1", ok, rsp_idx); end
    op_a_tb[1] = 32'h3F80_0000; op_b_tb[1] = 32'h4000_0000;
    op_a_tb[3] = 32'h4080_0000; op_b_tb[3] = 32'h3F80_0000;
    req_valid = 4'b1010;
    wait_rsp(ok);
    checks++; if (!ok || rsp_idx !== 2'd3) begin errors++; $display("FAIL ptr_first got ok=%b idx=%0d want ok=1 idx=3", ok, rsp_idx); end
    checks++; if (rsp_z !== 32'h40A0_0000) begin errors++; $display("FAIL ptr_first_z got %h want 40a00000", rsp_z); end
    wait_rsp(ok);
    req_valid = '0;
    checks++; if (!ok || rsp_idx !== 2'd1) begin errors++; $display("FAIL ptr_second got ok=%b idx=%0d want ok=1 idx=1", ok, rsp_idx); end
    checks++; if (rsp_z !== 32'h4040_0000) begin errors++; $display("FAIL ptr_second_z got %h want 40400000", rsp_z); end
    @(negedge clk);
    checks++; if (ops_done !== 16'd3) begin errors++; $display("FAIL ptr_ops_done got %0d want 3", ops_done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    rsp_ready = 1'b0;
    issue(2'd2, 32'h4040_0000, 32'h3F80_0000, ok);
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_rsp got timeout want rsp_valid"); end
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got %b want 1", c, rsp_valid); end
      checks++; if (rsp_z !== 32'h4080_0000 || rsp_idx !== 2'd2) begin errors++; $display("FAIL bp_hold_%0d got z=%h idx=%0d want z=40800000 idx=2", c, rsp_z, rsp_idx); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready_%0d got %b want 0000", c, req_ready); end
      checks++; if ({adder_a_stb, adder_b_stb, adder_z_ack} !== 3'b000) begin errors++; $display("FAIL bp_adder_%0d got %b want 000", c, {adder_a_stb, adder_b_stb, adder_z_ack}); end
      @(negedge clk);
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_11 got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b want 0", rsp_valid); end
    checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL bp_ops_done got %0d want 1", ops_done); end
  endtask

  task automatic test_ack_delay();
    bit ok;
    int a0, b0, z0, e0, u0;
    do_reset();
    ack_dly = 5;
    a0 = a_xfers; b0 = b_xfers; z0 = z_xfers; e0 = a_stb_edges; u0 = a_unstable;
    issue(2'd2, 32'h4000_0000, 32'h3F80_0000, ok);
    wait_rsp(ok);
    checks++; if (!ok || rsp_z !== 32'h4040_0000 || rsp_idx !== 2'd2) begin errors++; $display("FAIL ack_rsp got ok=%b z=%h idx=%0d want ok=1 z=40400000 idx=2", ok, rsp_z, rsp_idx); end
    checks++; if (a_xfers - a0 != 1 || b_xfers - b0 != 1 || z_xfers - z0 != 1) begin errors++; $display("FAIL ack_xfers got a=%0d b=%0d z=%0d want 1 each", a_xfers - a0, b_xfers - b0, z_xfers - z0); end
    checks++; if (a_stb_edges - e0 != 7) begin errors++; $display("FAIL ack_stb_hold got %0d want 7", a_stb_edges - e0); end
    checks++; if (a_unstable - u0 != 0) begin errors++; $display("FAIL ack_a_stable got %0d want 0", a_unstable - u0); end
    checks++; if (sa !== 32'h4000_0000 || sb !== 32'h3F80_0000) begin errors++; $display("FAIL ack_operands got a=%h b=%h want 40000000 3f800000", sa, sb); end
    @(negedge clk);
    ack_dly = 0;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    bit seen;
    do_reset();
    issue(2'd3, 32'h4080_0000, 32'h3F80_0000, ok);
    wait_rsp(ok);
    @(negedge clk);
    checks++; if (!ok || ops_done !== 16'd1 || rsp_idx !== 2'd3) begin errors++; $display("FAIL mid_setup got ok=%b ops=%0d idx=%0d want 1 1 3", ok, ops_done, rsp_idx); end
    z_dly = 50;
    issue(2'd1, 32'h3F80_0000, 32'h3F80_0000, ok);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (adder_z_ack) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_wait_z got timeout want adder_z_ack"); end
    repeat (2) @(negedge clk);
    req_valid = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || adder_z_ack !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl got busy=%b zack=%b valid=%b want 0 0 0", busy, adder_z_ack, rsp_valid); end
    checks++; if (rsp_z !== 32'h0 || rsp_idx !== 2'd0) begin errors++; $display("FAIL mid_reset_rsp got z=%h idx=%0d want 0 0", rsp_z, rsp_idx); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL mid_reset_ops got %0d want 0", ops_done); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_req_ready got %b want 0000", req_ready); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    z_dly = 1;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_abandon got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    issue(2'd0, 32'hBF80_0000, 32'h3F80_0000, ok);
    wait_rsp(ok);
    checks++; if (!ok || rsp_z !== 32'h0000_0000 || rsp_idx !== 2'd0) begin errors++; $display("FAIL mid_fresh got ok=%b z=%h idx=%0d want ok=1 z=00000000 idx=0", ok, rsp_z, rsp_idx); end
    @(negedge clk);
    checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL mid_fresh_ops got %0d want 1", ops_done); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a_tb[i] = '0;
      op_b_tb[i] = '0;
    end
    test_reset();
    test_single_op();
    test_no_grant();
    test_round_robin();
    test_ptr_wrap();
    test_backpressure();
    test_ack_delay();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish before 400us");
    $fatal(1, "watchdog expired");
  end

endmodule
